ddr3_cmd_fsm: RTL

Closed-page command sequencer that sits directly upstream of ddr3_ddl. It accepts single-burst read/write requests from the AXI front end and maps the byte address to bank/row/column. For each request it issues ACTIVATE, then READ or WRITE with auto-precharge, to the DDL command port. It also counts the refresh interval and issues REFRESH commands, with postponement tracking.

---
 rtl/ddr3_cmd_fsm_if.sv | 43 ++++
 rtl/ddr3_cmd_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_fsm_if.sv
// Request and DDL command-port bundle for ddr3_cmd_fsm.
// slave = sequencer side, master = front end / DDL model side.
interface ddr3_cmd_fsm_if #(
    parameter int ADDRS        = 32,
    parameter int DDR_ROW_BITS = 13
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_write_i;
    logic [ADDRS-1:0]        req_addr_i;
    logic                    ctl_req_o;
    logic                    ctl_seq_o;
    logic                    ctl_rdy_i;
    logic [2:0]              ctl_cmd_o;
    logic [2:0]              ctl_ba_o;
    logic [DDR_ROW_BITS-1:0] ctl_adr_o;

    modport slave (
        input  req_valid_i,
        input  req_write_i,
        input  req_addr_i,
        input  ctl_rdy_i,
        output req_ready_o,
        output ctl_req_o,
        output ctl_seq_o,
        output ctl_cmd_o,
        output ctl_ba_o,
        output ctl_adr_o
    );

    modport master (
        output req_valid_i,
        output req_write_i,
        output req_addr_i,
        output ctl_rdy_i,
        input  req_ready_o,
        input  ctl_req_o,
        input  ctl_seq_o,
        input  ctl_cmd_o,
        input  ctl_ba_o,
        input  ctl_adr_o
    );
endinterface

// File: rtl/ddr3_cmd_fsm.sv
// Closed-page DDR3 command sequencer: ACT then RD/WR with auto-precharge,
// plus a refresh interval timer with postponed-refresh accounting.
module ddr3_cmd_fsm #(
    parameter int ADDRS        = 32,
    parameter int DDR_ROW_BITS = 13,
    parameter int DDR_COL_BITS = 10,
    parameter int TRCD_CYCLES  = 2,
    parameter int TRC_CYCLES   = 6,
    parameter int TRFC_CYCLES  = 16,
    parameter int TREFI_CYCLES = 780
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 init_done_i,
    ddr3_cmd_fsm_if.slave        bus,
    output logic                 ref_pend_o,
    output logic                 ref_err_o
);

    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_ACTV = 3'b011;
    localparam logic [2:0] CMD_READ = 3'b101;
    localparam logic [2:0] CMD_WRIT = 3'b100;
    localparam logic [2:0] CMD_REFR = 3'b001;

    localparam int WAIT_A   = (TRCD_CYCLES > TRC_CYCLES) ? TRCD_CYCLES : TRC_CYCLES;
    localparam int WAIT_MAX = (WAIT_A > TRFC_CYCLES) ? WAIT_A : TRFC_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int REF_W    = $clog2(TREFI_CYCLES + 1);
    localparam int ROW_LO   = DDR_COL_BITS + 4;
    localparam int ROW_HI   = DDR_COL_BITS + DDR_ROW_BITS + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTV,
        S_WRCD,
        S_RDWR,
        S_WRC,
        S_REFR,
        S_WRFC
    } state_t;

    state_t                  state;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [REF_W-1:0]        ref_cnt;
    logic [3:0]              pend_cnt;
    logic                    err_q;
    logic [2:0]              bank_q;
    logic [DDR_COL_BITS-1:0] col_q;
    logic                    write_q;

    logic                    ctl_req_q;
    logic [2:0]              ctl_cmd_q;
    logic [2:0]              ctl_ba_q;
    logic [DDR_ROW_BITS-1:0] ctl_adr_q;

    logic                    req_ready;
    logic                    req_acc;
    logic                    cmd_acc;
    logic                    refr_acc;
    logic                    ref_expire;

    logic [DDR_COL_BITS-1:0] addr_col;
    logic [2:0]              addr_bank;
    logic [DDR_ROW_BITS-1:0] addr_row;
    logic [DDR_ROW_BITS-1:0] col_adr;
    logic                    unused_addr;

    assign addr_col  = {bus.req_addr_i[DDR_COL_BITS:4], 3'b000};
    assign addr_bank = bus.req_addr_i[DDR_COL_BITS+3:DDR_COL_BITS+1];
    assign addr_row  = bus.req_addr_i[ROW_HI:ROW_LO];

    assign unused_addr = ^{bus.req_addr_i[3:0], bus.req_addr_i[ADDRS-1:ROW_HI+1]};

    // A10 high selects auto-precharge on the column command
    always_comb begin
        col_adr                     = '0;
        col_adr[DDR_COL_BITS-1:0]   = col_q;
        col_adr[10]                 = 1'b1;
    end

    assign req_ready  = (state == S_IDLE) && init_done_i && (pend_cnt == 4'd0);
    assign req_acc    = bus.req_valid_i && req_ready;
    assign cmd_acc    = ctl_req_q && bus.ctl_rdy_i;
    assign refr_acc   = cmd_acc && (state == S_REFR);
    assign ref_expire = init_done_i && (ref_cnt == '0);

    assign bus.req_ready_o = req_ready;
    assign bus.ctl_req_o   = ctl_req_q;
    assign bus.ctl_seq_o   = 1'b0;
    assign bus.ctl_cmd_o   = ctl_cmd_q;
    assign bus.ctl_ba_o    = ctl_ba_q;
    assign bus.ctl_adr_o   = ctl_adr_q;
    assign ref_pend_o      = (pend_cnt != 4'd0);
    assign ref_err_o       = err_q;

    // Refresh interval timer and owed-refresh counter
    always_ff @(posedge clock) begin
        if (reset) begin
            ref_cnt  <= REF_W'(TREFI_CYCLES - 1);
            pend_cnt <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            if (init_done_i) begin
                if (ref_cnt == '0)
                    ref_cnt <= REF_W'(TREFI_CYCLES - 1);
                else
                    ref_cnt <= ref_cnt - 1'b1;
            end
            if (ref_expire && !refr_acc) begin
                if (pend_cnt == 4'd8)
                    err_q <= 1'b1;
                else
                    pend_cnt <= pend_cnt + 4'd1;
            end else if (refr_acc && !ref_expire) begin
                pend_cnt <= pend_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            bank_q    <= 3'd0;
            col_q     <= '0;
            write_q   <= 1'b0;
            ctl_req_q <= 1'b0;
            ctl_cmd_q <= CMD_NOP;
            ctl_ba_q  <= 3'd0;
            ctl_adr_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (init_done_i && pend_cnt != 4'd0) begin
                        state     <= S_REFR;
                        ctl_req_q <= 1'b1;
                        ctl_cmd_q <= CMD_REFR;
                        ctl_ba_q  <= 3'd0;
                        ctl_adr_q <= '0;
                    end else if (req_acc) begin
                        state     <= S_ACTV;
                        bank_q    <= addr_bank;
                        col_q     <= addr_col;
                        write_q   <= bus.req_write_i;
                        ctl_req_q <= 1'b1;
                        ctl_cmd_q <= CMD_ACTV;
                        ctl_ba_q  <= addr_bank;
                        ctl_adr_q <= addr_row;
                    end
                end
                S_ACTV: begin
                    if (cmd_acc) begin
                        state     <= S_WRCD;
                        wait_cnt  <= WAIT_W'(TRCD_CYCLES - 1);
                        ctl_req_q <= 1'b0;
                        ctl_cmd_q <= CMD_NOP;
                    end
                end
                S_WRCD: begin
                    if (wait_cnt == '0) begin
                        state     <= S_RDWR;
                        ctl_req_q <= 1'b1;
                        ctl_cmd_q <= write_q ? CMD_WRIT : CMD_READ;
                        ctl_ba_q  <= bank_q;
                        ctl_adr_q <= col_adr;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_RDWR: begin
                    if (cmd_acc) begin
                        state     <= S_WRC;
                        wait_cnt  <= WAIT_W'(TRC_CYCLES - 1);
                        ctl_req_q <= 1'b0;
                        ctl_cmd_q <= CMD_NOP;
                    end
                end
                S_WRC: begin
                    if (wait_cnt == '0)
                        state <= S_IDLE;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                S_REFR: begin
                    if (cmd_acc) begin
                        state     <= S_WRFC;
                        wait_cnt  <= WAIT_W'(TRFC_CYCLES - 1);
                        ctl_req_q <= 1'b0;
                        ctl_cmd_q <= CMD_NOP;
                    end
                end
                S_WRFC: begin
                    if (wait_cnt == '0)
                        state <= S_IDLE;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
